// File: rtl/game_input_ctrl.sv
// ============================================================================
// Module : game_input_ctrl
// Brief  : Key synchronizer/debouncer and command sequencer (clear / move+dir)
//          for the draw block. Optional auto-repeat: GAME_INPUT_AUTO_REPEAT_EN
// Rev    : 1.0
// ============================================================================
`default_nettype none

module game_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CLEAR_CYCLES    = 76800,
    parameter int MOVE_CYCLES     = 1024,
    parameter int REPEAT_CYCLES   = 12500000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_clear,
    output logic       clear,
    output logic       move,
    output logic [2:0] dir,
    output logic       busy
);

    localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int CNT_MAX = (CLEAR_CYCLES > MOVE_CYCLES) ? CLEAR_CYCLES : MOVE_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [DB_W-1:0]  c_DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CLEAR_LAST = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_MOVE_LAST  = CNT_W'(MOVE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_INIT_CLEAR = 2'd0,
        ST_IDLE       = 2'd1,
        ST_CLEAR      = 2'd2,
        ST_MOVE       = 2'd3
    } state_t;

    // Bit order: 0 up, 1 down, 2 left, 3 right, 4 clear (bit index = dir code)
    logic [4:0] w_raw;
    logic [4:0] w_deb;
    logic [4:0] w_press;

    assign w_raw = {key_clear, key_right, key_left, key_down, key_up};

    for (genvar gi = 0; gi < 5; gi++) begin : g_key
        logic            r_sync1;
        logic            r_sync2;
        logic            r_deb;
        logic            r_deb_d;
        logic [DB_W-1:0] r_cnt;

        always_ff @(posedge clock) begin
            if (reset) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
                r_deb   <= 1'b0;
                r_deb_d <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_sync1 <= w_raw[gi];
                r_sync2 <= r_sync1;
                r_deb_d <= r_deb;
                if (r_sync2 == r_deb) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_DB_LAST) begin
                    r_deb <= ~r_deb;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_deb[gi]   = r_deb;
        assign w_press[gi] = r_deb & ~r_deb_d;
    end

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_clear;
    logic             w_clear_nxt;
    logic             r_move;
    logic             w_move_nxt;
    logic [2:0]       r_dir;
    logic [2:0]       w_dir_nxt;

    logic [3:0]       w_rpt_req;
    logic [3:0]       w_dir_req;
    logic             w_accept;
    logic [1:0]       w_accept_idx;

    assign w_dir_req = w_press[3:0] | w_rpt_req;
    assign w_accept  = (r_state == ST_IDLE) && !w_press[4] && (|w_dir_req);

    always_comb begin
        w_accept_idx = 2'd3;
        if (w_dir_req[0]) begin
            w_accept_idx = 2'd0;
        end else if (w_dir_req[1]) begin
            w_accept_idx = 2'd1;
        end else if (w_dir_req[2]) begin
            w_accept_idx = 2'd2;
        end
    end

`ifdef GAME_INPUT_AUTO_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RPT_W-1:0] c_RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

    logic             r_rpt_act;
    logic             r_rpt_pend;
    logic [1:0]       r_rpt_key;
    logic [RPT_W-1:0] r_rpt_cnt;
    logic [3:0]       w_rpt_mask;
    logic             w_rpt_cancel;

    assign w_rpt_mask   = 4'b0001 << r_rpt_key;
    assign w_rpt_cancel = !w_deb[r_rpt_key] || (|(w_press & ~{1'b0, w_rpt_mask}));
    assign w_rpt_req    = r_rpt_pend ? w_rpt_mask : 4'b0000;

    // The accepted press cycle is count 0, so the accept edge loads 1.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rpt_act  <= 1'b0;
            r_rpt_pend <= 1'b0;
            r_rpt_key  <= 2'd0;
            r_rpt_cnt  <= '0;
        end else if (w_accept) begin
            r_rpt_act  <= 1'b1;
            r_rpt_pend <= 1'b0;
            r_rpt_key  <= w_accept_idx;
            r_rpt_cnt  <= RPT_W'(1);
        end else if (r_rpt_act && w_rpt_cancel) begin
            r_rpt_act  <= 1'b0;
            r_rpt_pend <= 1'b0;
            r_rpt_cnt  <= '0;
        end else if (r_rpt_act && !r_rpt_pend) begin
            if (r_rpt_cnt >= c_RPT_LAST) begin
                r_rpt_pend <= 1'b1;
                r_rpt_cnt  <= '0;
            end else begin
                r_rpt_cnt  <= r_rpt_cnt + 1'b1;
            end
        end
    end
`else
    assign w_rpt_req = 4'b0000;
`endif

    // Outputs are registered; a clear window only starts counting once
    // the registered clear is already high, so the post-reset window is full length.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_clear_nxt = r_clear;
        w_move_nxt  = r_move;
        w_dir_nxt   = r_dir;
        case (r_state)
            ST_INIT_CLEAR, ST_CLEAR: begin
                w_clear_nxt = 1'b1;
                if (r_clear) begin
                    if (r_cnt == c_CLEAR_LAST) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                        w_clear_nxt = 1'b0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            ST_MOVE: begin
                if (r_cnt == c_MOVE_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_move_nxt  = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_clear_nxt = 1'b0;
                w_move_nxt  = 1'b0;
                w_cnt_nxt   = '0;
                if (w_press[4]) begin
                    w_state_nxt = ST_CLEAR;
                    w_clear_nxt = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = ST_MOVE;
                    w_move_nxt  = 1'b1;
                    w_dir_nxt   = {1'b0, w_accept_idx};
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_INIT_CLEAR;
            r_cnt   <= '0;
            r_clear <= 1'b0;
            r_move  <= 1'b0;
            r_dir   <= 3'b000;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_clear <= w_clear_nxt;
            r_move  <= w_move_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

    assign clear = r_clear;
    assign move  = r_move;
    assign dir   = r_dir;
    assign busy  = r_clear | r_move;

endmodule

`default_nettype wire

// File: tb/tb_game_input_ctrl.sv
// ============================================================================
// Module : tb_game_input_ctrl
// Brief  : Directed bench for game_input_ctrl (D=4, CLEAR=8, MOVE=5, REPEAT=20)
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_game_input_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       key_up, key_down, key_left, key_right, key_clear;
    logic       clear, move, busy;
    logic [2:0] dir;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    game_input_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .CLEAR_CYCLES    (8),
        .MOVE_CYCLES     (5),
        .REPEAT_CYCLES   (20)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .key_up    (key_up),
        .key_down  (key_down),
        .key_left  (key_left),
        .key_right (key_right),
        .key_clear (key_clear),
        .clear     (clear),
        .move      (move),
        .dir       (dir),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic release_keys();
        key_up = 0; key_down = 0; key_left = 0; key_right = 0; key_clear = 0;
        ticks(12);
    endtask

    // Observation over n cycles: move/clear high cycles, move rising edges, overlap/busy errors
    task automatic observe(input int n, output int mv, output int cl, output int starts,
                           output int bad);
        logic prev;
        prev = move;
        mv = 0; cl = 0; starts = 0; bad = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (move) mv++;
            if (clear) cl++;
            if (move && !prev) starts++;
            if ((clear && move) || (busy !== (clear | move))) bad++;
            prev = move;
        end
    endtask

    task automatic test_reset();
        reset = 1;
        key_up = 0; key_down = 0; key_left = 0; key_right = 0; key_clear = 0;
        ticks(2);
        checks++;
        if (clear !== 1'b0 || move !== 1'b0 || busy !== 1'b0 || dir !== 3'b000) begin
            errors++;
            $display("FAIL reset_values: clear=%b move=%b busy=%b dir=%b, want 0 0 0 000",
                     clear, move, busy, dir);
        end
        reset = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (clear !== 1'b1 || busy !== 1'b1 || move !== 1'b0) begin
                errors++;
                $display("FAIL init_clear[%0d]: clear=%b busy=%b move=%b, want 1 1 0",
                         i, clear, busy, move);
            end
        end
        tick();
        checks++;
        if (clear !== 1'b0 || busy !== 1'b0 || dir !== 3'b000) begin
            errors++;
            $display("FAIL init_clear_end: clear=%b busy=%b dir=%b, want 0 0 000",
                     clear, busy, dir);
        end
    endtask

    task automatic test_debounce_move();
        int mv, cl, st, bad;
        key_left = 1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            checks++;
            if (move !== 1'b0) begin
                errors++;
                $display("FAIL debounce_latency[%0d]: move=%b, want 0", i, move);
            end
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (move !== 1'b1 || dir !== 3'b010 || busy !== 1'b1) begin
                errors++;
                $display("FAIL left_move[%0d]: move=%b dir=%b busy=%b, want 1 010 1",
                         i, move, dir, busy);
            end
        end
        tick();
        checks++;
        if (move !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL left_move_end: move=%b busy=%b, want 0 0", move, busy);
        end
        key_right = 1;
        ticks(3);
        key_right = 0;
        observe(15, mv, cl, st, bad);
        checks++;
        if (mv != 0 || dir !== 3'b010) begin
            errors++;
            $display("FAIL glitch: move_cycles=%0d dir=%b, want 0 010", mv, dir);
        end
        release_keys();
    endtask

    task automatic test_priority();
        int mv, cl, st, bad;
        key_up = 1; key_right = 1;
        ticks(7);
        checks++;
        if (move !== 1'b1 || dir !== 3'b000) begin
            errors++;
            $display("FAIL up_right_prio: move=%b dir=%b, want 1 000", move, dir);
        end
        observe(15, mv, cl, st, bad);
        checks++;
        if (mv != 4 || st != 0 || cl != 0 || bad != 0) begin
            errors++;
            $display("FAIL up_right_single: move_cyc=%0d starts=%0d clear_cyc=%0d bad=%0d, want 4 0 0 0",
                     mv, st, cl, bad);
        end
        release_keys();
        key_clear = 1; key_down = 1;
        ticks(7);
        checks++;
        if (clear !== 1'b1 || move !== 1'b0) begin
            errors++;
            $display("FAIL clear_wins: clear=%b move=%b, want 1 0", clear, move);
        end
        observe(20, mv, cl, st, bad);
        checks++;
        if (cl != 7 || mv != 0 || dir !== 3'b000 || bad != 0) begin
            errors++;
            $display("FAIL clear_window: clear_cyc=%0d move_cyc=%0d dir=%b bad=%0d, want 7 0 000 0",
                     cl, mv, dir, bad);
        end
        release_keys();
    endtask

    task automatic test_busy_drop();
        int mv, cl, st, bad;
        key_down = 1;
        ticks(2);
        key_right = 1;
        ticks(5);
        checks++;
        if (move !== 1'b1 || dir !== 3'b001) begin
            errors++;
            $display("FAIL down_move: move=%b dir=%b, want 1 001", move, dir);
        end
        observe(20, mv, cl, st, bad);
        checks++;
        if (mv != 4 || st != 0 || bad != 0) begin
            errors++;
            $display("FAIL busy_drop: move_cyc=%0d starts=%0d bad=%0d, want 4 0 0", mv, st, bad);
        end
        checks++;
        if (move !== 1'b0 || dir !== 3'b001) begin
            errors++;
            $display("FAIL dir_retained: move=%b dir=%b, want 0 001", move, dir);
        end
        release_keys();
    endtask

    task automatic test_reset_mid_move();
        int mv, cl, st, bad;
        key_left = 1;
        ticks(7);
        checks++;
        if (move !== 1'b1 || dir !== 3'b010) begin
            errors++;
            $display("FAIL pre_reset_move: move=%b dir=%b, want 1 010", move, dir);
        end
        ticks(2);
        reset = 1;
        tick();
        reset = 0;
        checks++;
        if (move !== 1'b0 || clear !== 1'b0 || busy !== 1'b0 || dir !== 3'b000) begin
            errors++;
            $display("FAIL reset_abort: move=%b clear=%b busy=%b dir=%b, want 0 0 0 000",
                     move, clear, busy, dir);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (clear !== 1'b1 || move !== 1'b0) begin
                errors++;
                $display("FAIL restart_clear[%0d]: clear=%b move=%b, want 1 0", i, clear, move);
            end
        end
        tick();
        checks++;
        if (clear !== 1'b0) begin
            errors++;
            $display("FAIL restart_clear_end: clear=%b, want 0", clear);
        end
        observe(15, mv, cl, st, bad);
        checks++;
        if (mv != 0 || cl != 0) begin
            errors++;
            $display("FAIL press_in_init_discarded: move_cyc=%0d clear_cyc=%0d, want 0 0", mv, cl);
        end
        release_keys();
    endtask

    task automatic test_auto_repeat();
        int   n_starts;
        int   start_at [8];
        int   dir_bad;
        logic prev;
        n_starts = 0;
        dir_bad  = 0;
        prev     = move;
        key_up   = 1;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (move && !prev) begin
                if (n_starts < 8) start_at[n_starts] = k;
                n_starts++;
            end
            if (move && dir !== 3'b000) dir_bad++;
            prev = move;
            if (k == 76) key_up = 0;
        end
        checks++;
        if (dir_bad != 0) begin
            errors++;
            $display("FAIL repeat_dir: cycles with wrong dir=%0d, want 0", dir_bad);
        end
`ifdef GAME_INPUT_AUTO_REPEAT_EN
        checks++;
        if (n_starts != 4) begin
            errors++;
            $display("FAIL repeat_count: moves=%0d, want 4", n_starts);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (start_at[i] != 7 + 20 * i) begin
                    errors++;
                    $display("FAIL repeat_time[%0d]: start=%0d, want %0d",
                             i, start_at[i], 7 + 20 * i);
                end
            end
        end
`else
        checks++;
        if (n_starts != 1 || start_at[0] != 7) begin
            errors++;
            $display("FAIL single_move_per_press: moves=%0d first=%0d, want 1 at 7",
                     n_starts, start_at[0]);
        end
`endif
        release_keys();
    endtask

    initial begin
        test_reset();
        test_debounce_move();
        test_priority();
        test_busy_drop();
        test_reset_mid_move();
        test_auto_repeat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/game_input_ctrl.md
Name: game_input_ctrl

Overview:
- Command front-end feeding the Monument Valley top-level draw block.
- Turns raw player inputs (four direction keys, one clear key) into the level-held clear, move and dir[2:0] controls that the top-level draw block and its sprite and clear-screen FSMs consume.
- Synchronizes, debounces and edge-detects the keys, then sequences commands. Each command holds its control high for a fixed draw window, so the downstream FSM finishes before the next command starts.
- Issues one full-screen clear after reset.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive stable synchronized cycles before a debounced key level changes
CLEAR_CYCLES, 76800, cycles clear is held high (320x240 pixels, one per cycle)
MOVE_CYCLES, 1024, cycles move is held high per step
REPEAT_CYCLES, 12500000, auto-repeat period; used only with AUTO_REPEAT_EN

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
key_up  input  1  raw direction key, active-high, asynchronous to clock
key_down  input  1  raw direction key, active-high, asynchronous
key_left  input  1  raw direction key, active-high, asynchronous
key_right  input  1  raw direction key, active-high, asynchronous
key_clear  input  1  raw clear key, active-high, asynchronous
clear  output  1  clear-screen enable to the draw block
move  output  1  sprite move enable to the draw block
dir  output  3  direction code: 000 up, 001 down, 010 left, 011 right; 1xx never driven
busy  output  1  high while clear or move is asserted

Behaviour:
Clock and reset:
- One clock; reset is synchronous and active-high.
- Reset values, effective on the first clock edge with reset=1:
  - clear=0, move=0, dir=000, busy=0.
  - State INIT_CLEAR with counter=0.
  - All synchronizer, debounce and edge registers cleared (debounced=0).
- Reset asserted mid-command aborts it on that edge and restarts at INIT_CLEAR.

Input path, per key:
- 2-FF synchronizer.
- Debounce counter:
  - Resets to 0 whenever the synchronized level equals the debounced level.
  - Otherwise increments.
  - On reaching DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
- Press event = debounced 0->1, a one-cycle pulse.
- Latency: raw edge to press pulse = 2 + DEBOUNCE_CYCLES cycles.
- Glitches shorter than DEBOUNCE_CYCLES never produce an event.

State machine (states, outputs and transitions):
- INIT_CLEAR:
  - clear=1, busy=1.
  - Counts CLEAR_CYCLES cycles, then goes to IDLE.
  - Entered only after reset.
- IDLE:
  - clear=0, move=0, busy=0.
  - Clear press -> CLEAR on the next edge.
  - Else any direction press -> MOVE on the next edge; dir latched the same edge.
  - Direction priority: up > down > left > right.
  - Clear press and direction press in the same cycle: clear wins and the direction press is dropped.
- CLEAR:
  - clear=1 for exactly CLEAR_CYCLES cycles, then IDLE.
- MOVE:
  - move=1 for exactly MOVE_CYCLES cycles, then IDLE.
  - dir is held stable for the whole window and retained afterwards until the next accepted move.

Invariants and boundary rules:
- clear and move are never both 1.
- busy = clear | move.
- Press events arriving in any state other than IDLE are discarded, not queued.
- Each command occupies one state entry. The counter runs 0..N-1 and clears on exit; no wrap.
- Minimum gap between commands is one IDLE cycle; outputs are low during it.
- Counter widths are $clog2 of the largest of the parameters they count.
- Parameter values of 1 are legal: the output is high for a single cycle.

Optional Feature:
Macro: GAME_INPUT_AUTO_REPEAT_EN.
- When defined:
  - While the same direction key stays debounced-high and the FSM is in IDLE, a synthetic press for that key fires every REPEAT_CYCLES cycles.
  - The repeat timer starts at the accepted press and counts across MOVE.
  - If the timer expires during MOVE, the repeat is issued in the first IDLE cycle.
  - Release, or a different key pressed, resets the timer.
- When undefined:
  - No repeat timer is instantiated; REPEAT_CYCLES is ignored.
  - One move per physical press only.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, CLEAR_CYCLES=8, MOVE_CYCLES=5, REPEAT_CYCLES=20.
1. Release reset -> clear=1 for exactly 8 cycles starting at the first edge, then clear=0, busy=0, dir=000.
2. In IDLE, hold key_left high -> press pulse 6 cycles later. The next edge gives move=1 for 5 cycles with dir=010; a 3-cycle key_right glitch produces nothing.
3. key_up and key_right rise on the same cycle -> single move, dir=000. key_clear rising with key_down -> clear=1 for 8 cycles, no move.
4. Press key_down, then press key_right during the move window -> one move with dir=001 only. After the window, dir stays 001 and move=0.
5. Assert reset for 1 cycle at cycle 3 of a move -> next edge move=0, clear=1, and INIT_CLEAR restarts for 8 cycles.
6. With GAME_INPUT_AUTO_REPEAT_EN, hold key_up for 70 cycles after its press -> moves begin at press+1, +20, +40, +60, each with dir=000. Without the macro -> exactly one move.
